// File: rtl/tt_bridge_pkg.sv
// Shared definitions for the TinyTapeout byte-serial register bridge.
// State encoding, command fields, uio bit positions and the status address.
package tt_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_DATA = 2'd2
    } state_t;

    localparam int CMD_WR_BIT = 7;
    localparam int ADDR_MSB   = 6;
    localparam int ADDR_LSB   = 0;

    localparam int IN_VALID  = 0;
    localparam int IN_READY  = 1;
    localparam int OUT_VALID = 2;
    localparam int OUT_READY = 3;
    localparam int ERR       = 4;

    localparam logic [7:0] UIO_OE_MASK = 8'h16;
    localparam logic [6:0] STATUS_ADDR = 7'h7F;

    function automatic int cnt_width(input int bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/tt_bridge_regfile.sv
// Register bank for the byte bridge: one synchronous write port,
// one combinational read port; out-of-range addresses read 0, write nothing.
module tt_bridge_regfile #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic [6:0]                   waddr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [6:0]                   raddr_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic [DATA_W*NUM_REGS-1:0]   regs_flat_o
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0] NREGS7 = 7'(NUM_REGS);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              unused_addr;

    assign unused_addr = ^{waddr_i, raddr_i};

    // Storage: cleared by reset, written only for in-range addresses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i < NREGS7)) begin
            mem_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    // Read port: bad addresses return all zeros.
    always_comb begin
        rdata_o = '0;
        if (raddr_i < NREGS7) begin
            rdata_o = mem_q[raddr_i[AW-1:0]];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat_o[g*DATA_W +: DATA_W] = mem_q[g];
    end

endmodule

// File: rtl/tt_byte_reg_bridge.sv
// Byte-serial valid/ready register bridge for a TinyTapeout user project.
// Optional macro TT_BRIDGE_ERRCNT_EN adds a bad-address counter at 0x7F.
module tt_byte_reg_bridge
    import tt_bridge_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ena,
    input  logic [7:0]                  ui_in,
    input  logic [7:0]                  uio_in,
    output logic [7:0]                  uo_out,
    output logic [7:0]                  uio_out,
    output logic [7:0]                  uio_oe,
    output logic [DATA_W*NUM_REGS-1:0]  regs_flat
);

    localparam int BYTES = DATA_W / 8;
    localparam int CW = cnt_width(BYTES);
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);
    localparam logic [6:0] NREGS7 = 7'(NUM_REGS);

    state_t              state_q, state_d;
    logic                in_valid, out_ready;
    logic                in_ready, out_valid;
    logic                in_fire, out_fire;
    logic                cmd_wr, cmd_bad, cmd_status;
    logic [6:0]          cmd_addr, addr_q;
    logic [CW-1:0]       cnt_q, cnt_nx;
    logic                last_byte;
    logic [CW+2:0]       off_q, off_nx;
    logic [DATA_W-1:0]   wbuf_q, snap_q;
    logic [DATA_W-1:0]   wr_word, rd_word, rf_rdata;
    logic [7:0]          uo_q;
    logic                err_q;
    logic                rf_we;
    logic                unused_uio;

    assign in_valid   = ena & uio_in[IN_VALID];
    assign out_ready  = ena & uio_in[OUT_READY];
    assign unused_uio = ^{uio_in[7:4], uio_in[2:1]};

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    assign cmd_wr   = ui_in[CMD_WR_BIT];
    assign cmd_addr = ui_in[ADDR_MSB:ADDR_LSB];
    assign cmd_bad  = !(cmd_addr < NREGS7) && !cmd_status;

    assign cnt_nx    = cnt_q + CW'(1);
    assign last_byte = (cnt_q == LAST);
    assign off_q     = {cnt_q, 3'b000};
    assign off_nx    = {cnt_nx, 3'b000};

    assign rf_we = (state_q == WR_DATA) && in_fire && last_byte;

    tt_bridge_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk_i       (clk),
        .rst_i       (rst),
        .we_i        (rf_we),
        .waddr_i     (addr_q),
        .wdata_i     (wr_word),
        .raddr_i     (cmd_addr),
        .rdata_o     (rf_rdata),
        .regs_flat_o (regs_flat)
    );

`ifdef TT_BRIDGE_ERRCNT_EN
    logic [7:0] errcnt_q;

    assign cmd_status = (cmd_addr == STATUS_ADDR);

    // Saturating count of bad commands; a write to the status address clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            errcnt_q <= '0;
        end else if ((state_q == IDLE) && in_fire && cmd_bad) begin
            if (errcnt_q != 8'hFF) begin
                errcnt_q <= errcnt_q + 8'd1;
            end
        end else if (rf_we && (addr_q == STATUS_ADDR)) begin
            errcnt_q <= '0;
        end
    end
`else
    assign cmd_status = 1'b0;
`endif

    // Word captured at read-command acceptance.
    always_comb begin
        rd_word = rf_rdata;
`ifdef TT_BRIDGE_ERRCNT_EN
        if (cmd_status) begin
            rd_word = DATA_W'(errcnt_q);
        end
`endif
    end

    // Final write word: assembled bytes with the current byte merged in.
    always_comb begin
        wr_word = wbuf_q;
        wr_word[off_q +: 8] = ui_in;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = cmd_wr ? WR_DATA : RD_DATA;
                end
            end
            WR_DATA: begin
                if (in_fire && last_byte) begin
                    state_d = IDLE;
                end
            end
            RD_DATA: begin
                if (out_fire && last_byte) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready  = 1'b1;
            WR_DATA: in_ready  = 1'b1;
            RD_DATA: out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Address latch, byte counter, write assembly, read snapshot and err.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            cnt_q  <= '0;
            wbuf_q <= '0;
            snap_q <= '0;
            uo_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_fire) begin
                        addr_q <= cmd_addr;
                        cnt_q  <= '0;
                        wbuf_q <= '0;
                        if (!cmd_wr) begin
                            snap_q <= rd_word;
                            uo_q   <= rd_word[7:0];
                        end
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (in_fire) begin
                        wbuf_q[off_q +: 8] <= ui_in;
                        cnt_q <= last_byte ? '0 : cnt_nx;
                    end
                end
                RD_DATA: begin
                    if (out_fire) begin
                        if (last_byte) begin
                            cnt_q <= '0;
                            uo_q  <= '0;
                        end else begin
                            cnt_q <= cnt_nx;
                            uo_q  <= snap_q[off_nx +: 8];
                        end
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    // Status byte on the bidirectional pins.
    always_comb begin
        uio_out            = '0;
        uio_out[IN_READY]  = in_ready;
        uio_out[OUT_VALID] = out_valid;
        uio_out[ERR]       = err_q;
    end

    assign uo_out = uo_q;
    assign uio_oe = UIO_OE_MASK;

endmodule

// File: doc/tt_byte_reg_bridge.md
# tt_byte_reg_bridge

Parametrised byte-serial register bridge for the TinyTapeout user-project top. A host drives commands and data through the 8-bit dedicated inputs under a valid/ready handshake and reads registers back on the dedicated outputs. The block holds a bank of NUM_REGS registers, each DATA_W bits wide, and exposes them flat to the user logic. It replaces hard-wired pin usage with a generic, width- and depth-configurable control path.

## Interface
- DATA_W, 16: register width; must be a multiple of 8, range 8..32; BYTES = DATA_W/8
- NUM_REGS, 8: number of registers; range 1..127
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  design selected; when low, in_valid and out_ready are treated as 0
- ui_in  in  8  command/data byte
- uio_in  in  8  bit0 in_valid, bit3 out_ready; other bits ignored
- uo_out  out  8  read-data byte, registered
- uio_out  out  8  bit1 in_ready, bit2 out_valid, bit4 err; other bits 0
- uio_oe  out  8  constant 8'b0001_0110
- regs_flat  out  DATA_W*NUM_REGS  register bank; reg i occupies bits [i*DATA_W +: DATA_W]

## Operation
- Command byte: bit7 = 1 write, 0 read; bits[6:0] = address.
- FSM has three states:
  - IDLE: in_ready = 1. A byte accepted with a write command latches the address, clears the byte counter and moves to WR_DATA. A read command snapshots the addressed word and moves to RD_DATA.
  - WR_DATA: in_ready = 1. Accepts BYTES data bytes, LSB first. On the last byte, commits the word to the register at the same edge and returns to IDLE.
  - RD_DATA: in_ready = 0, out_valid = 1. uo_out holds snapshot byte k, LSB first. Each out_valid & out_ready edge advances k. After byte BYTES-1 is transferred, returns to IDLE.
- Bad address (>= NUM_REGS, and not the status address when enabled):
  - err is set and stays set until rst.
  - A write still consumes BYTES data bytes and discards them.
  - A read returns BYTES bytes of 0x00.
- The byte counter wraps only through the state exit; it never exceeds BYTES-1.
- uo_out is 0x00 outside RD_DATA.
- The read snapshot is taken at command acceptance. Later register changes do not affect bytes already in flight.

## Timing
- Reset state: state IDLE; all registers, regs_flat, uo_out and err are 0; in_ready = 1; out_valid = 0.
- While rst is high, all handshake inputs are ignored.
- A transfer occurs at any rising edge where valid & ready are both 1. Input bytes can be accepted back-to-back, one per cycle.
- Write latency: regs_flat shows the new word the cycle after the last data byte is accepted.
- Read latency: the command is accepted at edge T. out_valid and byte 0 appear after edge T (visible in cycle T+1).
- Read bytes stream without bubbles while out_ready is held high. After the final transfer, in_ready = 1 in the next cycle.
- Holding out_ready low stalls the read. uo_out and out_valid stay stable.
- A rst asserted mid-transaction aborts it: a partial write is discarded, and state, counter and snapshot clear at that edge.
- ena low mid-transaction only pauses the handshake. State is retained.

## Configuration
- Macro: TT_BRIDGE_ERRCNT_EN.
- Defined:
  - Adds an 8-bit saturating counter of bad-address commands, which stops at 0xFF.
  - A read of address 0x7F returns the count in byte 0 and 0x00 in the upper bytes.
  - Address 0x7F is not counted as bad and does not set err.
  - A write to 0x7F consumes its bytes and clears the counter.
- Undefined: 0x7F is an ordinary bad address; there is no counter logic.

## Structure
- Package tt_bridge_pkg holds:
  - the state enum (IDLE, WR_DATA, RD_DATA);
  - the command bit positions (CMD_WR_BIT = 7, address field [6:0]);
  - the uio bit indices (IN_VALID = 0, IN_READY = 1, OUT_VALID = 2, OUT_READY = 3, ERR = 4);
  - UIO_OE_MASK = 8'h16;
  - STATUS_ADDR = 7'h7F.
- Sub-module tt_bridge_regfile: NUM_REGS × DATA_W storage with one synchronous write port, one combinational read port and a regs_flat output. The FSM, byte assembly and snapshot live in the top.

## Test plan
- Reset then idle (DATA_W = 16, NUM_REGS = 8): rst high for 2 cycles -> uo_out = 0x00, uio_out = 0x02, uio_oe = 0x16, regs_flat = 0.
- Write then read back:
  - Write 0x83, 0x34, 0x12 on consecutive cycles -> reg3 = 0x1234 one cycle after the last byte.
  - Read 0x03 with out_ready held high -> uo_out = 0x34 then 0x12 on consecutive cycles; in_ready returns the next cycle.
- Read stall: read reg3 with out_ready low for 5 cycles -> out_valid = 1 and uo_out = 0x34 held stable; byte 0x12 appears after out_ready rises.
- Bad address:
  - Write 0x8A, 0xAA, 0xBB -> err = 1 and regs_flat unchanged.
  - Read 0x0A -> 0x00, 0x00 returned.
  - With TT_BRIDGE_ERRCNT_EN, a subsequent read 0x7F -> 0x02, 0x00.
- Reset mid-write: send 0x81, 0x55, then assert rst -> reg1 = 0, state IDLE; next command is accepted normally.
- ena gating: ena low while in_valid is high with 0x80 -> nothing accepted; raise ena -> command accepted at the next edge.
